// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, datapath select encodings and ARM condition evaluation
// for the multicycle ARM control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } statetype_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // flags is {N,Z,C,V}; the reserved 1111 encoding never executes
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: instruction fields and ALU flags into the control unit, datapath controls out.
interface mc_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/mc_condlogic.sv
// mc_condlogic: Flags register, condition check, CondExReg and gating of the
// architectural write enables.
module mc_condlogic
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flag_en,
    input  logic       cond_load,
    input  logic       pcs,
    input  logic       next_pc,
    input  logic       reg_w,
    input  logic       mem_w,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);
    logic [3:0] flags;
    logic       cond_ex_reg;
    logic [1:0] flag_write;

    assign flag_write = flag_en ? (flag_w & {2{cond_ex_reg}}) : 2'b00;
    assign pc_write   = next_pc | (pcs & cond_ex_reg);
    assign reg_write  = reg_w & cond_ex_reg;
    assign mem_write  = mem_w & cond_ex_reg;

    // the decision is frozen at DECODE so this instruction's own flag update cannot gate it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags       <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (cond_load) cond_ex_reg <= cond_holds(cond, flags);
            if (flag_write[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_write[0]) flags[1:0] <= alu_flags[1:0];
        end
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM control unit; Moore main FSM plus ALU decoder,
// feeding mc_condlogic for conditional execution.
module mc_controller
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);
    statetype_t state, state_next;
    logic       next_pc, branch, reg_w, mem_w, alu_op;
    logic       ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_control, flag_w;
    logic       pc_write, reg_write, mem_write, pcs, exec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        alu_op     = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_next = bus.Op == 2'b01 ? MEMADR :
                             bus.Op == 2'b10 ? BRANCH :
                             bus.Op == 2'b11 ? UNKNOWN :
                             bus.Funct[5]    ? EXECUTEI : EXECUTER;
            end
            MEMADR: begin
                alu_src_b  = SRCB_IMM;
                state_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECUTER: begin
                alu_op     = 1'b1;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b  = SRCB_IMM;
                alu_op     = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // unrecognised data-processing functions fall back to ADD and never touch the flags
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin
                    alu_control = ALU_ADD;
                    flag_w      = {2{bus.Funct[0]}};
                end
                4'b0010: begin
                    alu_control = ALU_SUB;
                    flag_w      = {2{bus.Funct[0]}};
                end
                4'b0000: begin
                    alu_control = ALU_AND;
                    flag_w      = {bus.Funct[0], 1'b0};
                end
                4'b1100: begin
                    alu_control = ALU_ORR;
                    flag_w      = {bus.Funct[0], 1'b0};
                end
                default: begin
                    alu_control = ALU_ADD;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

    assign exec = (state == EXECUTER) || (state == EXECUTEI);
    assign pcs  = ((bus.Rd == 4'b1111) & reg_w) | branch;

    mc_condlogic u_condlogic (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.Cond),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .flag_en   (exec),
        .cond_load (state == DECODE),
        .pcs       (pcs),
        .next_pc   (next_pc),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .mem_write (mem_write)
    );

    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle ARM control unit: one Moore FSM plus instruction/ALU decoders and condition logic. It drives every mux select and write enable of the multicycle datapath (PC, IR, register file, memory, ALU source and result muxes) from the latched instruction fields and the ALU flags. It sits directly upstream of the datapath and is its only source of control.

## Interface
Parameters: none.

- `clk` in 1: system clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-high; forces FETCH and clears Flags/CondExReg
- `Cond` in 4: Instr[31:28]
- `Op` in 2: Instr[27:26]
- `Funct` in 6: Instr[25:20]
- `Rd` in 4: Instr[15:12]
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, combinational
- `PCWrite` out 1: PC register enable
- `MemWrite` out 1: memory write enable
- `RegWrite` out 1: register-file write enable
- `IRWrite` out 1: instruction register enable
- `AdrSrc` out 1: 0 = PC, 1 = ALUOut
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult
- `ALUSrcA` out 1: 0 = A, 1 = PC
- `ALUSrcB` out 2: 00 WriteData, 01 ExtImm, 10 constant 4
- `ALUControl` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR
- `ImmSrc` out 2: equals Op
- `RegSrc` out 2: [0] = (Op==10), [1] = (Op==01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. Next state by Op:
  - Op=01: MEMADR
  - Op=00 with Funct[5]=1: EXECUTEI; with Funct[5]=0: EXECUTER
  - Op=10: BRANCH
  - Op=11: UNKNOWN
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next state is MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1. Next state is FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next state is ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1. Next state is FETCH.
- UNKNOWN: all enables 0. Next state is FETCH.
- Unlisted selects are 0 in every state.
- ALU decoder:
  - ALUOp=0: ADD, FlagW=00.
  - ALUOp=1, Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other value gives ADD with FlagW=00.
  - FlagW[1] (N,Z) = Funct[0]. FlagW[0] (C,V) = Funct[0] & (ADD|SUB).
- Condition check uses Cond against the Flags register:
  - Standard ARM mapping for 0000–1101 (EQ … LE).
  - 1110 (AL) gives 1; 1111 gives 0.
- Gating:
  - PCS = (Rd==1111 & RegW) | Branch
  - PCWrite = NextPC | (PCS & CondExReg)
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
  - FlagWrite = FlagW & {2{CondExReg}}, applied only in EXECUTER/EXECUTEI

## Timing
- Cycles per instruction: LDR 5; STR 4; data-processing 4; branch 3; UNKNOWN 3.
- CondExReg loads the condition-check result only on the DECODE→next edge. It holds through the rest of the instruction, so flag updates in EXECUTE never affect that instruction's own write-back.
- Flags[3:2] load ALUFlags[3:2] at the end of EXECUTE when FlagWrite[1]=1. Flags[1:0] load ALUFlags[1:0] when FlagWrite[0]=1.
- All outputs are combinational from state, instruction fields and CondExReg. There are no registered outputs.
- Reset state: state=FETCH, Flags=0000, CondExReg=0.
- Outputs while in reset: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00, MemWrite=0, RegWrite=0.
- Reset asserted mid-instruction aborts it immediately, with no pending write.

## Structure
- Package `mc_pkg` holds:
  - `statetype_t` enum
  - ALUControl encodings
  - ALUSrcB encodings
  - ResultSrc encodings
  - Cond code constants
- One sub-module, `mc_condlogic`, contains the Flags register, the condition check, CondExReg and the write gating.
- The FSM and decoders stay in `mc_controller`.

## Test plan
- **ADD R1,R2,R3** (Cond=1110, Op=00, Funct=001000) after reset: states FETCH→DECODE→EXECUTER→ALUWB→FETCH. ALUControl=00 in EXECUTER. RegWrite=1 only in ALUWB.
- **LDR** (Op=01, Funct=011001): 5 cycles. AdrSrc=1 in MEMREAD. RegWrite=1 with ResultSrc=01 in MEMWB. MemWrite=0 throughout.
- **SUBS** (Funct=000101) with ALUFlags=0100 in EXECUTER: Flags become 0100.
  - A following BEQ (Cond=0000, Op=10) gives PCWrite=1 in BRANCH.
  - A following BNE gives PCWrite=0.
- **STRNE** with Z=1: MEMWRITE is reached but MemWrite=0. Back to FETCH after 4 cycles.
- **ADD PC,…** (Rd=1111, Cond=1110): PCWrite=1 and RegWrite=1 in ALUWB.
- **Reset** asserted in EXECUTER with Flags=1111: FETCH outputs appear immediately, Flags=0000 and CondExReg=0. After release, the first fetch proceeds normally.
